// File: rtl/fft_out_serializer_if.sv
// Output stream bundle of fft_out_serializer: one complex sample per beat with valid/ready.
// The serializer drives through the master modport; the consumer uses the slave modport.
interface fft_out_serializer_if #(
  parameter int WIDTH_OUTPUT = 13,
  parameter int ADDR_W       = 9
);
  logic signed [WIDTH_OUTPUT-1:0] dout_i;
  logic signed [WIDTH_OUTPUT-1:0] dout_q;
  logic                           dout_valid;
  logic                           dout_ready;
  logic [ADDR_W-1:0]              dout_idx;
  logic                           dout_first;
  logic                           dout_last;

  modport master (
    output dout_i, dout_q, dout_valid, dout_idx, dout_first, dout_last,
    input  dout_ready
  );

  modport slave (
    input  dout_i, dout_q, dout_valid, dout_idx, dout_first, dout_last,
    output dout_ready
  );
endinterface

// File: rtl/fft_out_serializer.sv
// Captures one full complex FFT frame in a single cycle and streams it out one sample per beat.
// Define FFT_OUT_BITREV_EN to read the buffer in bit-reversed index order (natural frequency order).
module fft_out_serializer #(
  parameter int TOTAL_SIZE   = 512,
  parameter int WIDTH_OUTPUT = 13,
  parameter int ADDR_W       = 9
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           din_en,
  input  logic signed [WIDTH_OUTPUT-1:0] din_re [0:TOTAL_SIZE-1],
  input  logic signed [WIDTH_OUTPUT-1:0] din_im [0:TOTAL_SIZE-1],
  fft_out_serializer_if.master           dout_if,
  output logic                           busy,
  output logic                           overflow,
  input  logic                           ovf_clr
);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e                         state_q, state_d;
  logic [ADDR_W-1:0]              cnt_q, cnt_d;
  logic                           overflow_q, overflow_d;
  logic signed [WIDTH_OUTPUT-1:0] buf_re_q [0:TOTAL_SIZE-1];
  logic signed [WIDTH_OUTPUT-1:0] buf_re_d [0:TOTAL_SIZE-1];
  logic signed [WIDTH_OUTPUT-1:0] buf_im_q [0:TOTAL_SIZE-1];
  logic signed [WIDTH_OUTPUT-1:0] buf_im_d [0:TOTAL_SIZE-1];
  logic [ADDR_W-1:0]              rd_idx;
  logic                           streaming;
  logic                           last_cnt;
  logic                           drop;

`ifdef FFT_OUT_BITREV_EN
  function automatic logic [ADDR_W-1:0] bit_rev(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    for (int b = 0; b < ADDR_W; b++) begin
      r[b] = v[ADDR_W-1-b];
    end
    return r;
  endfunction

  assign rd_idx = bit_rev(cnt_q);
`else
  assign rd_idx = cnt_q;
`endif

  assign streaming = (state_q == STREAM);
  assign last_cnt  = (cnt_q == ADDR_W'(TOTAL_SIZE - 1));
  // Single buffer: any frame offered while streaming (even on the final beat) is lost.
  assign drop      = streaming && din_en;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_re_d   = buf_re_q;
    buf_im_d   = buf_im_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (din_en) begin
          buf_re_d = din_re;
          buf_im_d = din_im;
          cnt_d    = '0;
          state_d  = STREAM;
        end
      end
      STREAM: begin
        if (dout_if.dout_ready) begin
          if (last_cnt) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A drop in the same cycle as a clear must still be reported.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_re_q <= buf_re_d;
    buf_im_q <= buf_im_d;
  end

  // Data outputs are forced to zero outside STREAM so reset and idle look identical downstream.
  assign dout_if.dout_valid = streaming;
  assign dout_if.dout_i     = streaming ? buf_re_q[rd_idx] : '0;
  assign dout_if.dout_q     = streaming ? buf_im_q[rd_idx] : '0;
  assign dout_if.dout_idx   = streaming ? rd_idx : '0;
  assign dout_if.dout_first = streaming && (cnt_q == '0);
  assign dout_if.dout_last  = streaming && last_cnt;
  assign busy               = streaming;
  assign overflow           = overflow_q;

endmodule

// File: tb/tb_fft_out_serializer.sv
// Self-checking bench for fft_out_serializer: scoreboard of expected stream beats plus
// per-scenario checks of latency, handshake hold, overflow and reset behaviour.
module tb_fft_out_serializer;

  localparam int N  = 512;
  localparam int W  = 13;
  localparam int AW = 9;

  typedef struct {
    logic [AW-1:0]       idx;
    logic signed [W-1:0] re;
    logic signed [W-1:0] im;
    logic                first;
    logic                last;
  } exp_t;

  logic                clk     = 1'b0;
  logic                rstn    = 1'b0;
  logic                din_en  = 1'b0;
  logic                ovf_clr = 1'b0;
  logic signed [W-1:0] din_re [0:N-1];
  logic signed [W-1:0] din_im [0:N-1];
  logic                busy;
  logic                overflow;

  exp_t exp_q[$];
  int   tests  = 0;
  int   errors = 0;

  fft_out_serializer_if #(.WIDTH_OUTPUT(W), .ADDR_W(AW)) dout_if ();

  fft_out_serializer #(
    .TOTAL_SIZE  (N),
    .WIDTH_OUTPUT(W),
    .ADDR_W      (AW)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .din_en  (din_en),
    .din_re  (din_re),
    .din_im  (din_im),
    .dout_if (dout_if),
    .busy    (busy),
    .overflow(overflow),
    .ovf_clr (ovf_clr)
  );

  always #5 clk = ~clk;

  // Expected buffer index for stream position k.
  function automatic logic [AW-1:0] tb_rd_idx(input int k);
    logic [AW-1:0] kk;
    logic [AW-1:0] r;
    kk = AW'(k);
`ifdef FFT_OUT_BITREV_EN
    r = '0;
    for (int b = 0; b < AW; b++) begin
      r = {r[AW-2:0], kk[b]};
    end
`else
    r = kk;
`endif
    return r;
  endfunction

  task automatic fill_frame(input int mode);
    for (int k = 0; k < N; k++) begin
      case (mode)
        0: begin din_re[k] = W'(k);            din_im[k] = W'(-k);           end
        1: begin din_re[k] = W'(N - 1 - k);    din_im[k] = W'(k + 100);      end
        2: begin din_re[k] = W'(7 * k - 2000); din_im[k] = W'(1000 - 3 * k); end
        3: begin din_re[k] = -13'sd4096;       din_im[k] = 13'sd4095;        end
        default: begin din_re[k] = 13'sd4095;  din_im[k] = -13'sd4096;       end
      endcase
    end
  endtask

  task automatic push_frame();
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.idx   = tb_rd_idx(k);
      e.re    = din_re[e.idx];
      e.im    = din_im[e.idx];
      e.first = (k == 0);
      e.last  = (k == N - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input int budget, output int vcyc);
    vcyc = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (!dout_if.dout_valid) break;
      vcyc++;
    end
  endtask

  // Scoreboard: every accepted beat must match the next expected beat in order.
  task automatic sb_monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && dout_if.dout_valid && dout_if.dout_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL sb_unexpected: beat idx=%0d i=%0d with nothing expected",
                   dout_if.dout_idx, dout_if.dout_i);
        end else begin
          e = exp_q.pop_front();
          if (dout_if.dout_idx !== e.idx || dout_if.dout_i !== e.re || dout_if.dout_q !== e.im ||
              dout_if.dout_first !== e.first || dout_if.dout_last !== e.last) begin
            errors++;
            $display("[TB] FAIL sb_beat: got idx=%0d i=%0d q=%0d first=%b last=%b, expected idx=%0d i=%0d q=%0d first=%b last=%b",
                     dout_if.dout_idx, dout_if.dout_i, dout_if.dout_q, dout_if.dout_first,
                     dout_if.dout_last, e.idx, e.re, e.im, e.first, e.last);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    dout_if.dout_ready = 1'b1;
    fill_frame(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({dout_if.dout_valid, dout_if.dout_idx, dout_if.dout_i, dout_if.dout_q, dout_if.dout_first,
         dout_if.dout_last, busy, overflow} !== 40'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%b idx=%0d i=%0d q=%0d first=%b last=%b busy=%b ovf=%b, expected all 0",
               dout_if.dout_valid, dout_if.dout_idx, dout_if.dout_i, dout_if.dout_q,
               dout_if.dout_first, dout_if.dout_last, busy, overflow);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    tests++;
    if (dout_if.dout_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got valid=%b busy=%b, expected 0 0", dout_if.dout_valid, busy);
    end
  endtask

  task automatic test_full_rate();
    int vcyc;
    dout_if.dout_ready = 1'b1;
    fill_frame(0);
    @(posedge clk); #1;
    din_en = 1'b1;
    push_frame();
    @(negedge clk);
    tests++;
    if (dout_if.dout_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL latency_early: got valid=%b, expected 0 in strobe cycle", dout_if.dout_valid);
    end
    @(posedge clk); #1;
    din_en = 1'b0;
    @(negedge clk);
    tests++;
    if (dout_if.dout_valid !== 1'b1 || busy !== 1'b1 || dout_if.dout_first !== 1'b1) begin
      errors++;
      $display("[TB] FAIL latency: got valid=%b busy=%b first=%b, expected 1 1 1",
               dout_if.dout_valid, busy, dout_if.dout_first);
    end
    @(negedge clk);
    tests++;
    if (dout_if.dout_idx !== tb_rd_idx(1) || dout_if.dout_first !== 1'b0) begin
      errors++;
      $display("[TB] FAIL second_idx: got idx=%0d first=%b, expected idx=%0d first=0",
               dout_if.dout_idx, dout_if.dout_first, tb_rd_idx(1));
    end
    wait_idle(N + 20, vcyc);
    tests++;
    if (vcyc + 2 !== N) begin
      errors++;
      $display("[TB] FAIL full_rate_cycles: got %0d valid cycles, expected %0d", vcyc + 2, N);
    end
    tests++;
    if (dout_if.dout_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL full_rate_end: got valid=%b busy=%b pending=%0d, expected 0 0 0",
               dout_if.dout_valid, busy, exp_q.size());
    end
  endtask

  task automatic test_ready_toggle();
    int   vcyc;
    logic held;
    logic [AW-1:0]       s_idx;
    logic signed [W-1:0] s_i, s_q;
    logic                s_f, s_l;
    fill_frame(1);
    dout_if.dout_ready = 1'b0;
    @(posedge clk); #1;
    din_en = 1'b1;
    push_frame();
    @(posedge clk); #1;
    din_en = 1'b0;
    dout_if.dout_ready = 1'b1;
    held = 1'b0;
    vcyc = 0;
    for (int c = 0; c < 2 * N + 20; c++) begin
      @(negedge clk);
      if (!dout_if.dout_valid) break;
      vcyc++;
      if (held) begin
        tests++;
        if (dout_if.dout_idx !== s_idx || dout_if.dout_i !== s_i || dout_if.dout_q !== s_q ||
            dout_if.dout_first !== s_f || dout_if.dout_last !== s_l) begin
          errors++;
          $display("[TB] FAIL hold_stable: got idx=%0d i=%0d q=%0d, expected held idx=%0d i=%0d q=%0d",
                   dout_if.dout_idx, dout_if.dout_i, dout_if.dout_q, s_idx, s_i, s_q);
        end
      end
      held  = !dout_if.dout_ready;
      s_idx = dout_if.dout_idx;
      s_i   = dout_if.dout_i;
      s_q   = dout_if.dout_q;
      s_f   = dout_if.dout_first;
      s_l   = dout_if.dout_last;
      @(posedge clk); #1;
      dout_if.dout_ready = ~dout_if.dout_ready;
    end
    tests++;
    if (vcyc != 2 * N - 1 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL toggle_cycles: got %0d cycles pending=%0d, expected %0d cycles pending=0",
               vcyc, exp_q.size(), 2 * N - 1);
    end
    dout_if.dout_ready = 1'b1;
  endtask

  task automatic test_overflow();
    int vcyc;
    dout_if.dout_ready = 1'b1;
    fill_frame(1);
    @(posedge clk); #1;
    din_en = 1'b1;
    push_frame();
    @(posedge clk); #1;
    din_en = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    fill_frame(2);
    din_en = 1'b1;
    @(posedge clk); #1;
    din_en = 1'b0;
    @(negedge clk);
    tests++;
    if (overflow !== 1'b1 || dout_if.dout_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL drop_mid_stream: got ovf=%b valid=%b, expected 1 1", overflow, dout_if.dout_valid);
    end
    wait_idle(N, vcyc);
    tests++;
    if (overflow !== 1'b1 || dout_if.dout_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drop_stream_end: got ovf=%b valid=%b pending=%0d, expected 1 0 0",
               overflow, dout_if.dout_valid, exp_q.size());
    end
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    tests++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ovf_clear: got ovf=%b, expected 0", overflow);
    end
    fill_frame(0);
    @(posedge clk); #1;
    din_en = 1'b1;
    push_frame();
    @(posedge clk); #1;
    din_en = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    din_en  = 1'b1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    din_en  = 1'b0;
    ovf_clr = 1'b0;
    @(negedge clk);
    tests++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("[TB] FAIL set_beats_clear: got ovf=%b, expected 1", overflow);
    end
    @(posedge clk); #1;
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    tests++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_while_streaming: got ovf=%b, expected 0", overflow);
    end
    for (int c = 0; c < N; c++) begin
      @(posedge clk); #1;
      if (dout_if.dout_last) break;
    end
    tests++;
    if (dout_if.dout_last !== 1'b1) begin
      errors++;
      $display("[TB] FAIL last_timeout: got last=%b, expected 1 within budget", dout_if.dout_last);
    end
    din_en = 1'b1;
    @(posedge clk); #1;
    din_en = 1'b0;
    @(negedge clk);
    tests++;
    if (overflow !== 1'b1 || dout_if.dout_valid !== 1'b0 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drop_on_last: got ovf=%b valid=%b busy=%b pending=%0d, expected 1 0 0 0",
               overflow, dout_if.dout_valid, busy, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_stream();
    int vcyc;
    dout_if.dout_ready = 1'b1;
    fill_frame(1);
    @(posedge clk); #1;
    din_en = 1'b1;
    push_frame();
    @(posedge clk); #1;
    din_en = 1'b0;
    repeat (300) @(posedge clk);
    #2;
    rstn = 1'b0;
    exp_q.delete();
    #1;
    tests++;
    if ({dout_if.dout_valid, dout_if.dout_idx, dout_if.dout_i, dout_if.dout_q, dout_if.dout_first,
         dout_if.dout_last, busy, overflow} !== 40'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_stream: got valid=%b idx=%0d i=%0d q=%0d busy=%b ovf=%b, expected all 0",
               dout_if.dout_valid, dout_if.dout_idx, dout_if.dout_i, dout_if.dout_q, busy, overflow);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    fill_frame(2);
    @(posedge clk); #1;
    din_en = 1'b1;
    push_frame();
    @(posedge clk); #1;
    din_en = 1'b0;
    @(negedge clk);
    tests++;
    if (dout_if.dout_first !== 1'b1 || dout_if.dout_idx !== 9'd0 || dout_if.dout_i !== -13'sd2000) begin
      errors++;
      $display("[TB] FAIL restart_first: got first=%b idx=%0d i=%0d, expected 1 0 -2000",
               dout_if.dout_first, dout_if.dout_idx, dout_if.dout_i);
    end
    wait_idle(N + 20, vcyc);
    tests++;
    if (vcyc + 1 != N || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL restart_frame: got %0d cycles pending=%0d, expected %0d pending=0",
               vcyc + 1, exp_q.size(), N);
    end
  endtask

  task automatic test_back_to_back();
    int vcyc;
    dout_if.dout_ready = 1'b1;
    fill_frame(3);
    @(posedge clk); #1;
    din_en = 1'b1;
    push_frame();
    @(posedge clk); #1;
    din_en = 1'b0;
    @(negedge clk);
    tests++;
    if (dout_if.dout_i !== -13'sd4096 || dout_if.dout_q !== 13'sd4095) begin
      errors++;
      $display("[TB] FAIL extreme_values: got i=%0d q=%0d, expected -4096 4095",
               dout_if.dout_i, dout_if.dout_q);
    end
    for (int c = 0; c < N; c++) begin
      @(posedge clk); #1;
      if (dout_if.dout_last) break;
    end
    fill_frame(4);
    @(posedge clk); #1;
    din_en = 1'b1;
    push_frame();
    @(negedge clk);
    tests++;
    if (dout_if.dout_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL gap_idle: got valid=%b busy=%b, expected 0 0", dout_if.dout_valid, busy);
    end
    @(posedge clk); #1;
    din_en = 1'b0;
    wait_idle(N + 20, vcyc);
    tests++;
    if (vcyc != N || exp_q.size() != 0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_gap_frame: got %0d cycles pending=%0d ovf=%b, expected %0d 0 0",
               vcyc, exp_q.size(), overflow, N);
    end
  endtask

  initial begin
    dout_if.dout_ready = 1'b0;
    fork
      sb_monitor();
    join_none
    test_reset();
    test_full_rate();
    test_ready_toggle();
    test_overflow();
    test_reset_mid_stream();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/fft_out_serializer.md
Name: fft_out_serializer

Overview:
- Parallel-to-serial output stage: the counterpart of the input serial_to_parallel.
- Captures one full 512-point FFT result frame (do_re/do_im arrays plus the do_en strobe from fft_top) into an internal frame buffer.
- Streams the frame out one complex sample per cycle over a valid/ready interface.
- Sits after fft_top; feeds the output DMA / compare logic.

Parameters:
- TOTAL_SIZE, 512, points per frame; power of two.
- WIDTH_OUTPUT, 13, signed width of each real/imag sample.
- ADDR_W, 9, index width; must equal log2(TOTAL_SIZE).

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- din_en  input  1  one-cycle frame strobe; din_re/din_im are valid in this cycle.
- din_re  input  signed [WIDTH_OUTPUT-1:0] x [0:TOTAL_SIZE-1]  frame real parts.
- din_im  input  signed [WIDTH_OUTPUT-1:0] x [0:TOTAL_SIZE-1]  frame imaginary parts.
- dout_i  output  signed WIDTH_OUTPUT  streamed real sample.
- dout_q  output  signed WIDTH_OUTPUT  streamed imaginary sample.
- dout_valid  output  1  dout_* holds a valid sample.
- dout_ready  input  1  downstream accepts the sample.
- dout_idx  output  ADDR_W  buffer index of the current sample.
- dout_first  output  1  high with sample 0 of the frame.
- dout_last  output  1  high with the final sample of the frame.
- busy  output  1  a frame is held or streaming.
- overflow  output  1  sticky: a frame was dropped.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rstn=0, async): state=IDLE, counter=0. All outputs are 0: dout_i, dout_q, dout_valid, dout_idx, dout_first, dout_last, busy, overflow. Buffer contents are don't-care.
- State IDLE:
  - din_en=1: latch all 2*TOTAL_SIZE samples in one cycle, counter<=0, go to STREAM.
  - First sample appears at the next edge, so latency from din_en to dout_valid=1 is 1 cycle.
- State STREAM:
  - dout_valid=1, busy=1.
  - dout_i/dout_q = buffer[rd_idx(counter)]; dout_idx = rd_idx(counter).
  - dout_first = (counter==0); dout_last = (counter==TOTAL_SIZE-1).
  - Transfer occurs when dout_valid & dout_ready; the counter then increments.
  - Transfer with counter==TOTAL_SIZE-1: go to IDLE, counter<=0, dout_valid=0 next cycle.
- Handshake rules:
  - While dout_valid=1 and dout_ready=0, all dout_* outputs are held stable.
  - dout_valid never drops without a transfer, except on reset.
  - Full-rate streaming with dout_ready held at 1 takes exactly TOTAL_SIZE cycles per frame.
- Outputs: registered, driven directly from state/counter/buffer. No combinational path from dout_ready to dout_valid.
- Boundary conditions:
  - din_en during STREAM: frame dropped; buffer and stream unaffected; overflow<=1 next cycle.
  - din_en in the same cycle as the last transfer: also dropped, overflow set. Single buffer, no back-to-back acceptance.
  - ovf_clr and a drop in the same cycle: set wins, overflow=1.
  - din_en in IDLE is always accepted.
  - Reset mid-stream: frame discarded immediately; outputs go to reset values.
- Arithmetic: samples pass through bit-exact; no scaling, rounding or sign change.

Optional Feature:
- Macro: FFT_OUT_BITREV_EN.
- Defined:
  - rd_idx(counter) = bit-reverse of counter over ADDR_W bits, so a bit-reversed fft_top output is emitted in natural frequency order.
  - dout_idx reports the bit-reversed buffer index (e.g. counter 1 -> idx 256).
  - dout_first/dout_last remain tied to counter.
- Undefined: rd_idx(counter) = counter, i.e. the stream is in buffer order.

Test Plan:
1. Reset then frame with din_re[k]=k, din_im[k]=-k, dout_ready=1 -> dout_valid rises 1 cycle after din_en; 512 consecutive samples (k,-k) for k=0..511 (macro off); first on k=0, last on k=511; then valid=0, busy=0.
2. Same frame, dout_ready toggling 1,0,1,0 -> each sample held while ready=0; stream ends after exactly 1023 cycles; no sample duplicated or skipped.
3. Second din_en at stream sample 100 -> stream continues unchanged to 511; overflow=1 and stays high; ovf_clr pulse clears it; a simultaneous drop and ovf_clr leaves overflow=1.
4. rstn pulse low at sample 300 -> all outputs go to 0 immediately; next din_en restarts at sample 0 with the new frame data.
5. FFT_OUT_BITREV_EN defined, din_re[k]=k -> dout_i sequence 0,256,128,384,64,...; dout_idx matches; last sample 511; dout_last asserted on counter 511.
6. Extreme values: din_re=-4096, din_im=4095 on all points -> output is bit-exact with no sign change; din_en with zero gap after the previous frame's last transfer (IDLE) is accepted.
